fetch_unit: RTL and testbench

- Instruction-fetch stage and IF/DE pipeline register.
- Consumes the stall and control-redirect requests produced by hazard detection and applies them: holds the PC and the IF/DE register on stall, and squashes wrong-path instructions on redirect.
- Drives a single-outstanding req/ack instruction-memory interface.
- Carries one instruction that returns during a stall in a one-entry holding buffer.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: FSM state, default widths and the {valid, instr, pc} packet
// used for both the IF/DE register and the one-entry holding buffer.
package fetch_unit_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 16;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

  // Sized from the package defaults; the top's width parameters must match these.
  typedef struct packed {
    logic                   valid;
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/DE register, single-outstanding imem req/ack,
// stall/redirect handling and a one-entry buffer for data returning during a stall.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               de_valid_o,
  output logic [INSTR_W-1:0] de_instr_o,
  output logic [PC_W-1:0]    de_pc_o
);

  fetch_state_e    state_q, state_n;
  logic [PC_W-1:0] pc_q, pc_n;
  logic [PC_W-1:0] redir_q, redir_n;
  logic [PC_W-1:0] tgt;
  fetch_pkt_t      de_q, de_n;
  fetch_pkt_t      buf_q, buf_n;
  logic            ack;

  // A full buffer suppresses the request, so it can never be overwritten.
  assign imem_req_o  = !rst_i && ((state_q == FETCH && !buf_q.valid) || state_q == DROP);
  assign imem_addr_o = pc_q;
  assign ack         = imem_req_o && imem_ack_i;
  assign tgt         = redirect_pc_i & ~PC_W'(1);

  assign de_valid_o = de_q.valid;
  assign de_instr_o = de_q.instr;
  assign de_pc_o    = de_q.pc;

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    redir_n = redir_q;
    de_n    = de_q;
    buf_n   = buf_q;
    if (redirect_i) begin
      de_n.valid  = 1'b0;
      buf_n.valid = 1'b0;
      if (imem_req_o && !ack) begin
        // Keep the address stable until the in-flight access returns.
        state_n = DROP;
        redir_n = tgt;
      end else begin
        state_n = FETCH;
        pc_n    = tgt;
      end
    end else if (state_q == DROP) begin
      if (ack) begin
        state_n = FETCH;
        pc_n    = redir_q;
      end
    end else if (ack) begin
      if (stall_i) buf_n = '{valid: 1'b1, instr: imem_rdata_i, pc: pc_q};
      else         de_n  = '{valid: 1'b1, instr: imem_rdata_i, pc: pc_q};
      pc_n = pc_q + PC_W'(PC_INC);
    end else if (!stall_i) begin
      if (buf_q.valid) begin
        de_n        = buf_q;
        buf_n.valid = 1'b0;
      end else begin
        de_n.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      redir_q <= '0;
      de_q    <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      redir_q <= redir_n;
      de_q    <= de_n;
      buf_q   <= buf_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: expected IF/DE packets are queued when an ack is
// driven and compared by a monitor when a new instruction shows up in IF/DE.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i;
  logic [15:0] imem_rdata_i;
  logic        de_valid_o;
  logic [15:0] de_instr_o;
  logic [15:0] de_pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;
  exp_t exp_q[$];

  fetch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .de_valid_o(de_valid_o),
    .de_instr_o(de_instr_o), .de_pc_o(de_pc_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: a new IF/DE entry is a valid one that differs from last cycle's.
  logic        prev_v  = 1'b0;
  logic [15:0] prev_pc = '0;
  always @(negedge clk_i) begin
    if (de_valid_o && !(prev_v && de_pc_o == prev_pc)) begin
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no output", de_pc_o, de_instr_o);
      end else begin
        e = exp_q.pop_front();
        if (de_pc_o !== e.pc || de_instr_o !== e.instr) begin
          n_fail++;
          $display("FAIL sb_de: got pc=%h instr=%h, expected pc=%h instr=%h",
                   de_pc_o, de_instr_o, e.pc, e.instr);
        end
      end
    end
    prev_v  = de_valid_o;
    prev_pc = de_pc_o;
  end

  // One cycle: apply inputs, clock, and return at the following negedge.
  task automatic drive(input logic a, input logic keep, input logic s,
                       input logic r, input logic [15:0] rpc);
    imem_ack_i    = a;
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = rpc;
    imem_rdata_i  = 16'h1000 + imem_addr_o;
    if (a && keep) begin
      n_checks++;
      if (imem_req_o !== 1'b1) begin
        n_fail++;
        $display("FAIL ack_without_req: req=%b, expected 1 at addr %h", imem_req_o, imem_addr_o);
      end
      exp_q.push_back('{pc: imem_addr_o, instr: 16'h1000 + imem_addr_o});
    end
    @(posedge clk_i);
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    redirect_i = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    @(negedge clk_i);
    chk("reset_req", {15'b0, imem_req_o}, 16'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("reset_valid", {15'b0, de_valid_o}, 16'h0);
    chk("reset_instr", de_instr_o, 16'h0);
    chk("reset_pc", de_pc_o, 16'h0);
    chk("reset_addr", imem_addr_o, 16'h0000);
    chk("reset_req_after", {15'b0, imem_req_o}, 16'h1);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      chk("stream_addr", imem_addr_o, 16'(2 * i));
      drive(1, 1, 0, 0, '0);
      chk("stream_valid", {15'b0, de_valid_o}, 16'h1);
    end
  endtask

  task automatic test_stall_buffer();
    chk("stall_addr", imem_addr_o, 16'h0006);
    drive(0, 0, 0, 0, '0);                       // wait 1, no stall: bubble
    chk("bubble_valid", {15'b0, de_valid_o}, 16'h0);
    chk("bubble_pc_hold", de_pc_o, 16'h0004);
    drive(0, 0, 1, 0, '0);                       // wait 2, stall rises
    chk("stall_wait_addr", imem_addr_o, 16'h0006);
    drive(1, 1, 1, 0, '0);                       // ack during stall -> buffer
    chk("buf_req_low", {15'b0, imem_req_o}, 16'h0);
    chk("buf_de_hold", {15'b0, de_valid_o}, 16'h0);
    drive(1, 0, 1, 0, '0);                       // stray ack with req low is ignored
    chk("buf_req_low2", {15'b0, imem_req_o}, 16'h0);
    drive(0, 0, 0, 0, '0);                       // stall drops: buffer -> de
    chk("unbuf_pc", de_pc_o, 16'h0006);
    chk("unbuf_req", {15'b0, imem_req_o}, 16'h1);
    chk("unbuf_addr", imem_addr_o, 16'h0008);
    drive(1, 1, 0, 0, '0);
  endtask

  task automatic test_redirect_drop();
    chk("drop_pre_addr", imem_addr_o, 16'h000A);
    drive(0, 0, 0, 1, 16'h0041);
    chk("drop_addr_stable", imem_addr_o, 16'h000A);
    chk("drop_req", {15'b0, imem_req_o}, 16'h1);
    chk("drop_valid", {15'b0, de_valid_o}, 16'h0);
    drive(0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);                       // squashed data returns
    chk("drop_tgt_addr", imem_addr_o, 16'h0040);
    chk("drop_valid2", {15'b0, de_valid_o}, 16'h0);
    drive(1, 1, 0, 0, '0);
    // two redirects while the access is outstanding: the later one wins
    drive(0, 0, 0, 1, 16'h0100);
    drive(0, 0, 0, 1, 16'h0200);
    chk("drop2_addr_stable", imem_addr_o, 16'h0042);
    drive(1, 0, 0, 0, '0);
    chk("drop2_latest_wins", imem_addr_o, 16'h0200);
    drive(1, 1, 0, 0, '0);
  endtask

  task automatic test_redirect_ack_stall_buf();
    drive(1, 0, 1, 0, '0);                       // 0x0202 lands in the buffer
    chk("rab_req_low", {15'b0, imem_req_o}, 16'h0);
    drive(1, 0, 1, 1, 16'h0080);
    chk("rab_valid", {15'b0, de_valid_o}, 16'h0);
    chk("rab_req", {15'b0, imem_req_o}, 16'h1);
    chk("rab_addr", imem_addr_o, 16'h0080);
    drive(0, 0, 0, 0, '0);                       // buffer must not drain into de
    chk("rab_buf_squashed", {15'b0, de_valid_o}, 16'h0);
    drive(1, 1, 0, 0, '0);
    drive(1, 0, 0, 1, 16'h0010);                 // redirect coincident with ack in FETCH
    chk("rack_addr", imem_addr_o, 16'h0010);
    chk("rack_valid", {15'b0, de_valid_o}, 16'h0);
    drive(1, 1, 0, 0, '0);
  endtask

  task automatic test_wrap();
    drive(1, 0, 0, 1, 16'hFFFF);                 // bit 0 of the target is cleared
    chk("wrap_tgt", imem_addr_o, 16'hFFFE);
    drive(1, 1, 0, 0, '0);
    chk("wrap_de_pc", de_pc_o, 16'hFFFE);
    chk("wrap_addr", imem_addr_o, 16'h0000);
  endtask

  task automatic test_reset_in_drop();
    drive(1, 1, 0, 0, '0);                       // fetch 0x0000
    drive(0, 0, 0, 1, 16'h0300);                 // enter DROP, req pending at 0x0002
    chk("rd_req", {15'b0, imem_req_o}, 16'h1);
    rst_i = 1'b1; imem_ack_i = 1'b1; imem_rdata_i = 16'hDEAD;
    #1;
    chk("rd_req_in_reset", {15'b0, imem_req_o}, 16'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0; imem_ack_i = 1'b0;
    #1;
    chk("rd_addr", imem_addr_o, 16'h0000);
    chk("rd_valid", {15'b0, de_valid_o}, 16'h0);
    chk("rd_req_after", {15'b0, imem_req_o}, 16'h1);
    drive(1, 1, 0, 0, '0);
    chk("rd_next_addr", imem_addr_o, 16'h0002);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_buffer();
    test_redirect_drop();
    test_redirect_ack_stall_buf();
    test_wrap();
    test_reset_in_drop();
    drive(0, 0, 0, 0, '0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
